// File: rtl/ysyx_25010008_mem_pkg.sv
// Shared constants and types for the handshaked memory responder.
package ysyx_25010008_mem_pkg;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   localparam logic [1:0]  RESP_DECERR      = 2'b11;
   localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
   // Galois taps for x^8+x^6+x^5+x^4+1, right-shifting form
   localparam logic [7:0]  LFSR_TAPS        = 8'hB8;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_RESP,
      WR_WAIT,
      WR_RESP
   } state_e;

endpackage

// File: rtl/ysyx_25010008_mem_lfsr8.sv
// 8-bit Galois LFSR, steps once per cycle with adv_i high; exposes its low OUT_W bits.
module ysyx_25010008_lfsr8
   import ysyx_25010008_mem_pkg::*;
#(
   parameter logic [7:0]  SEED  = 8'hA5,
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv_i,
   output logic [OUT_W-1:0] rnd_o
);

   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/ysyx_25010008_mem_responder.sv
// Single-outstanding AXI4-Lite-style memory slave with fixed or LFSR-driven latency.
module ysyx_25010008_mem_responder
   import ysyx_25010008_mem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = MEM_BASE_DEFAULT,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LAT_MODE    = 0,
   parameter int unsigned FIXED_LAT   = 1,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic        bvalid_q, bvalid_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [2:0]       rnd_c;
   logic [2:0]       lat_c;
   logic             rd_acc_c, wr_acc_c;
   logic             wr_ok_c, cur_ok_c;
   logic [IDX_W-1:0] wr_idx_c, cur_idx_c;

   // 33-bit difference so addresses below the base wrap to a huge value
   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} - {1'b0, ADDR_BASE}) < SPAN;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - ADDR_BASE) >> 2);
   endfunction

   ysyx_25010008_lfsr8 #(
      .SEED  (LFSR_SEED),
      .OUT_W (3)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .adv_i (rd_acc_c || wr_acc_c),
      .rnd_o (rnd_c)
   );

   assign arready  = (state_q == IDLE);
   assign awready  = (state_q == IDLE) && !arvalid;
   assign wready   = awready;
   assign rd_acc_c = arvalid && arready;
   assign wr_acc_c = awvalid && wvalid && awready && wready;
   assign lat_c    = (LAT_MODE != 0) ? rnd_c : 3'(FIXED_LAT);
   assign wr_ok_c  = in_range(awaddr);
   assign wr_idx_c = word_idx(awaddr);

   // Writes commit at the acceptance edge; the array is never reset
   always_ff @(posedge clk) begin
      if (wr_acc_c && wr_ok_c) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               mem_q[wr_idx_c][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      bvalid_d  = bvalid_q;
      cur_ok_c  = in_range(addr_q);
      cur_idx_c = word_idx(addr_q);

      unique case (state_q)
         IDLE: begin
            if (rd_acc_c) begin
               state_d = RD_WAIT;
               addr_d  = araddr;
               cnt_d   = lat_c;
            end else if (wr_acc_c) begin
               state_d = WR_WAIT;
               addr_d  = awaddr;
               cnt_d   = lat_c;
            end
         end
         RD_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d  = RD_RESP;
               rvalid_d = 1'b1;
               rdata_d  = cur_ok_c ? mem_q[cur_idx_c] : 32'h0;
               rresp_d  = cur_ok_c ? RESP_OKAY : RESP_DECERR;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RD_RESP: begin
            if (rready) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
            end
         end
         WR_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d  = WR_RESP;
               bvalid_d = 1'b1;
               bresp_d  = cur_ok_c ? RESP_OKAY : RESP_DECERR;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         WR_RESP: begin
            if (bready) begin
               state_d  = IDLE;
               bvalid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         addr_q   <= 32'h0;
         rdata_q  <= 32'h0;
         rresp_q  <= RESP_OKAY;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         bvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         bvalid_q <= bvalid_d;
      end
   end

   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign rvalid = rvalid_q;
   assign bresp  = bresp_q;
   assign bvalid = bvalid_q;

endmodule

// File: tb/tb_ysyx_25010008_mem_responder.sv
// Scoreboard bench: fixed-latency instance (index 0) and LFSR-latency instance (index 1).
module tb_ysyx_25010008_mem_responder;

   logic clk = 1'b0;
   logic rst;

   logic [1:0][31:0] araddr, awaddr, wdata, rdata;
   logic [1:0][3:0]  wstrb;
   logic [1:0][1:0]  rresp, bresp;
   logic [1:0]       arvalid, arready, rvalid, rready;
   logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;

   always #5 clk = ~clk;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      logic [1:0]  resp;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [2][4096];
   int          n_checks = 0;
   int          n_errors = 0;

   ysyx_25010008_mem_responder #(.LAT_MODE(0), .FIXED_LAT(1)) u_fix (
      .clk(clk), .rst(rst),
      .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
      .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
      .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
      .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
      .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
   );

   ysyx_25010008_mem_responder #(.LAT_MODE(1), .LFSR_SEED(8'hA5)) u_lfsr (
      .clk(clk), .rst(rst),
      .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
      .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
      .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
      .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
      .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (a < 32'h8000_4000);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - 32'h8000_0000) >> 2);
   endfunction

   // x^8+x^6+x^5+x^4+1 Galois step, written bit by bit
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      logic [7:0] n;
      n[7] = s[0];
      n[6] = s[7];
      n[5] = s[6] ^ s[0];
      n[4] = s[5] ^ s[0];
      n[3] = s[4] ^ s[0];
      n[2] = s[3];
      n[1] = s[2];
      n[0] = s[1];
      return n;
   endfunction

   task automatic exp_rd(input int d, input logic [31:0] a, input int lat, output logic [31:0] xd);
      exp_t e;
      e.is_rd = 1'b1;
      e.lat   = lat;
      e.data  = in_rng(a) ? mdl[d][widx(a)] : 32'h0;
      e.resp  = in_rng(a) ? 2'b00 : 2'b11;
      xd      = e.data;
      sb.push_back(e);
   endtask

   task automatic exp_wr(input int d, input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] s, input int lat);
      exp_t e;
      e.is_rd = 1'b0;
      e.lat   = lat;
      e.data  = 32'h0;
      e.resp  = in_rng(a) ? 2'b00 : 2'b11;
      if (in_rng(a)) begin
         for (int i = 0; i < 4; i++) begin
            if (s[i]) mdl[d][widx(a)][8*i +: 8] = v[8*i +: 8];
         end
      end
      sb.push_back(e);
   endtask

   task automatic resp_check(input int d, input bit is_rd, input int lat);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("resp_kind", 32'(is_rd), 32'(e.is_rd));
      if (e.lat >= 0) check(is_rd ? "rd_latency" : "wr_latency", 32'(lat), 32'(e.lat));
      if (is_rd) begin
         check("rdata", rdata[d], e.data);
         check("rresp", 32'(rresp[d]), 32'(e.resp));
      end else begin
         check("bresp", 32'(bresp[d]), 32'(e.resp));
      end
   endtask

   // Called at a negedge; returns at a negedge after the response has completed
   task automatic rd(input int d, input logic [31:0] a, input int lat, input int hold);
      int n;
      logic [31:0] xd;
      exp_rd(d, a, lat, xd);
      araddr[d] = a; arvalid[d] = 1'b1; rready[d] = (hold == 0);
      #1;
      n = 0;
      while (!arready[d] && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) check("ar_timeout", 32'(n), 32'd0);
      @(negedge clk);
      arvalid[d] = 1'b0;
      n = 0;
      while (!rvalid[d] && n < 40) begin @(negedge clk); n++; end
      resp_check(d, 1'b1, n);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid[d]), 32'd1);
            check("rdata_hold", rdata[d], xd);
         end
         rready[d] = 1'b1;
      end
      @(negedge clk);
      check("rvalid_drop", 32'(rvalid[d]), 32'd0);
      rready[d] = 1'b0;
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v,
                     input logic [3:0] s, input int lat);
      int n;
      exp_wr(d, a, v, s, lat);
      awaddr[d] = a; wdata[d] = v; wstrb[d] = s;
      awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b1;
      #1;
      n = 0;
      while (!(awready[d] && wready[d]) && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) check("aw_timeout", 32'(n), 32'd0);
      @(negedge clk);
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      n = 0;
      while (!bvalid[d] && n < 40) begin @(negedge clk); n++; end
      resp_check(d, 1'b0, n);
      @(negedge clk);
      check("bvalid_drop", 32'(bvalid[d]), 32'd0);
      bready[d] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  s;
      logic [31:0] xd;
      bit          got_r, got_b, drop, seen;
      int          n;

      rst = 1'b1;
      araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
      arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
      for (int i = 0; i < 4096; i++) begin
         u_fix.mem_q[i]  = 32'h0;
         mdl[0][i]       = 32'h0;
         u_lfsr.mem_q[i] = 32'h1000_0000 + 32'(i);
         mdl[1][i]       = 32'h1000_0000 + 32'(i);
      end
      u_fix.mem_q[0] = 32'hDEAD_BEEF;
      mdl[0][0]      = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_arready", 32'(arready[d]), 32'd1);
         check("rst_awready", 32'(awready[d]), 32'd1);
         check("rst_wready",  32'(wready[d]),  32'd1);
         check("rst_rvalid",  32'(rvalid[d]),  32'd0);
         check("rst_bvalid",  32'(bvalid[d]),  32'd0);
         check("rst_rdata",   rdata[d],        32'd0);
         check("rst_rresp",   32'(rresp[d]),   32'd0);
         check("rst_bresp",   32'(bresp[d]),   32'd0);
      end
      @(negedge clk);

      // Fixed latency 1: valid observed 2 cycles after acceptance
      rd(0, 32'h8000_0000, 2, 0);
      wr(0, 32'h8000_0004, 32'h1122_3344, 4'b0101, 2);
      rd(0, 32'h8000_0004, 2, 0);
      rd(0, 32'h8000_0006, 2, 0);
      rd(0, 32'h7FFF_FFFC, 2, 0);
      wr(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2);
      rd(0, 32'h8000_0000, 2, 0);
      wr(0, 32'h8000_0000, 32'h0BAD_F00D, 4'h0, 2);
      rd(0, 32'h8000_0000, 2, 0);
      wr(0, 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 2);
      rd(0, 32'h8000_3FFC, 2, 0);
      rd(0, 32'h8000_0004, 2, 5);

      // Read and write requested together: read first, write in the next IDLE
      exp_rd(0, 32'h8000_0000, -1, xd);
      exp_wr(0, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, -1);
      araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1; rready[0] = 1'b1;
      awaddr[0] = 32'h8000_0008; wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF;
      awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
      #1;
      check("sim_arready", 32'(arready[0]), 32'd1);
      check("sim_awready", 32'(awready[0]), 32'd0);
      @(negedge clk);
      arvalid[0] = 1'b0;
      #1;
      got_r = 1'b0; got_b = 1'b0; n = 0;
      while (!got_b && n < 40) begin
         if (rvalid[0] && !got_r) begin resp_check(0, 1'b1, -1); got_r = 1'b1; end
         if (bvalid[0]) begin resp_check(0, 1'b0, -1); got_b = 1'b1; end
         drop = awvalid[0] && awready[0] && wready[0];
         @(negedge clk);
         #1;
         if (drop) begin awvalid[0] = 1'b0; wvalid[0] = 1'b0; end
         n++;
      end
      if (!got_b) check("sim_timeout", 32'(n), 32'd0);
      check("sim_bvalid_drop", 32'(bvalid[0]), 32'd0);
      rready[0] = 1'b0; bready[0] = 1'b0;
      @(negedge clk);
      rd(0, 32'h8000_0008, 2, 0);

      // LFSR latency: L is lfsr[2:0] at acceptance, one step per transaction
      s = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         rd(1, 32'h8000_0000 + 32'(4 * i), int'(s[2:0]) + 1, 0);
         s = lfsr_next(s);
      end

      // Reset while in RD_WAIT aborts with no response
      araddr[1] = 32'h8000_0010; arvalid[1] = 1'b1; rready[1] = 1'b1;
      #1;
      check("abort_arready", 32'(arready[1]), 32'd1);
      @(negedge clk);
      arvalid[1] = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_rvalid", 32'(rvalid[1]), 32'd0);
      check("abort_idle", 32'(arready[1]), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rvalid[1]) seen = 1'b1;
      end
      check("abort_no_resp", 32'(seen), 32'd0);
      rready[1] = 1'b0;
      s = 8'hA5;
      rd(1, 32'h8000_0000, int'(s[2:0]) + 1, 0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
